// File: rtl/expr_eval_pkg.sv
// Shared definitions for the expression evaluator and the grammar checker:
// FSM states, character constants, class codes and the character classifier.
package expr_eval_pkg;

   typedef enum logic [1:0] {
      S_START = 2'd0,
      S_DIG   = 2'd1,
      S_OP    = 2'd2,
      S_ERR   = 2'd3
   } state_t;

   typedef enum logic [2:0] {
      C_DIG = 3'd0,
      C_ADD = 3'd1,
      C_MUL = 3'd2,
      C_EQ  = 3'd3,
      C_OTH = 3'd4
   } class_t;

   localparam logic [7:0] CH_ADD = 8'h2B;
   localparam logic [7:0] CH_MUL = 8'h2A;
   localparam logic [7:0] CH_EQ  = 8'h3D;
   localparam logic [7:0] CH_0   = 8'h30;
   localparam logic [7:0] CH_9   = 8'h39;

   function automatic class_t classify(input logic [7:0] ch);
      class_t c;
      if (ch >= CH_0 && ch <= CH_9) c = C_DIG;
      else if (ch == CH_ADD)        c = C_ADD;
      else if (ch == CH_MUL)        c = C_MUL;
      else if (ch == CH_EQ)         c = C_EQ;
      else                          c = C_OTH;
      return c;
   endfunction

endpackage

// File: rtl/expr_eval_if.sv
// Character-in / result-out bundle of the expression evaluator.
interface expr_eval_if #(parameter int W = 16);
   logic         in_valid;
   logic [7:0]   in;
   logic         ok;
   logic         res_valid;
   logic [W-1:0] result;
   logic         err;
   logic         ovf;

   modport master (output in_valid, in, input ok, res_valid, result, err, ovf);
   modport slave  (input in_valid, in, output ok, res_valid, result, err, ovf);
endinterface

// File: rtl/expr_eval_char_class.sv
// Combinational character classifier: ASCII byte -> class code and digit value.
module char_class
   import expr_eval_pkg::*;
(
   input  logic [7:0] ch,
   output class_t     cls,
   output logic [3:0] digit
);
   always_comb begin
      cls   = classify(ch);
      // '0'..'9' are 8'h30..8'h39, so the low nibble is the value
      digit = (cls == C_DIG) ? ch[3:0] : 4'd0;
   end
endmodule

// File: rtl/expr_eval.sv
// Evaluates "d(op d)*=" streams with '*' binding tighter than '+'.
// Optional saturating arithmetic and overflow flag when EXPR_SAT_EN is defined.
//
// state   | meaning
// S_START | expecting the first digit of an expression
// S_DIG   | last char was a digit; operator or '=' may follow
// S_OP    | last char was an operator; digit must follow
// S_ERR   | malformed expression; waiting for '=' to report it
module expr_eval
   import expr_eval_pkg::*;
#(
   parameter int W = 16
) (
   input  logic        clk,
   input  logic        clr_n,
   expr_eval_if.slave  bus
);
   class_t       cls;
   logic [3:0]   d;
   state_t       state, state_nxt;
   logic [W-1:0] sum, term, result, term_dig, sum_nxt;
   logic         mul_pend, ok, res_valid, err;
   logic         acc_dig, acc_add, acc_mul, good_eq, bad_eq;

   char_class u_char_class (.ch(bus.in), .cls(cls), .digit(d));

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n)            state <= S_START;
      else if (bus.in_valid) state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_START: state_nxt = (cls == C_DIG) ? S_DIG : (cls == C_EQ) ? S_START : S_ERR;
         S_DIG:   state_nxt = (cls == C_ADD || cls == C_MUL) ? S_OP :
                              (cls == C_EQ) ? S_START : S_ERR;
         S_OP:    state_nxt = (cls == C_DIG) ? S_DIG : (cls == C_EQ) ? S_START : S_ERR;
         S_ERR:   state_nxt = (cls == C_EQ) ? S_START : S_ERR;
         default: state_nxt = S_START;
      endcase
   end

   always_comb begin
      acc_dig = 1'b0;
      acc_add = 1'b0;
      acc_mul = 1'b0;
      good_eq = 1'b0;
      bad_eq  = 1'b0;
      if (bus.in_valid) begin
         acc_dig = (state == S_START || state == S_OP) && cls == C_DIG;
         acc_add = (state == S_DIG) && cls == C_ADD;
         acc_mul = (state == S_DIG) && cls == C_MUL;
         good_eq = (state == S_DIG) && cls == C_EQ;
         bad_eq  = (state != S_DIG) && cls == C_EQ;
      end
   end

`ifdef EXPR_SAT_EN
   logic [W+3:0] prod_full;
   logic [W:0]   sum_full;
   logic         sat_prod, sat_sum, ovf_acc, ovf;

   always_comb begin
      prod_full = {4'd0, term} * {{W{1'b0}}, d};
      sum_full  = {1'b0, sum} + {1'b0, term};
      sat_prod  = mul_pend && (|prod_full[W+3:W]);
      sat_sum   = sum_full[W];
      term_dig  = !mul_pend ? W'(d) : sat_prod ? '1 : prod_full[W-1:0];
      sum_nxt   = sat_sum ? '1 : sum_full[W-1:0];
   end

   // ovf_acc collects saturations inside the expression; ovf publishes it at '='
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         ovf_acc <= 1'b0;
         ovf     <= 1'b0;
      end else if (good_eq || bad_eq) begin
         ovf     <= ovf_acc | (good_eq & sat_sum);
         ovf_acc <= 1'b0;
      end else if ((acc_dig && sat_prod) || (acc_add && sat_sum)) begin
         ovf_acc <= 1'b1;
      end
   end

   assign bus.ovf = ovf;
`else
   always_comb begin
      term_dig = mul_pend ? W'(term * W'(d)) : W'(d);
      sum_nxt  = sum + term;
   end

   assign bus.ovf = 1'b0;
`endif

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         sum       <= '0;
         term      <= '0;
         mul_pend  <= 1'b0;
         result    <= '0;
         ok        <= 1'b0;
         res_valid <= 1'b0;
         err       <= 1'b0;
      end else begin
         res_valid <= good_eq;
         err       <= bad_eq;
         if (bus.in_valid) begin
            ok <= (state_nxt == S_DIG);
            if (good_eq || bad_eq) begin
               sum      <= '0;
               term     <= '0;
               mul_pend <= 1'b0;
               if (good_eq) result <= sum_nxt;
            end else begin
               if (acc_dig) term <= term_dig;
               if (acc_mul) mul_pend <= 1'b1;
               if (acc_add) begin
                  sum      <= sum_nxt;
                  mul_pend <= 1'b0;
               end
            end
         end
      end
   end

   assign bus.ok        = ok;
   assign bus.res_valid = res_valid;
   assign bus.result    = result;
   assign bus.err       = err;
endmodule

// File: tb/tb_expr_eval.sv
// Self-checking bench for expr_eval: W=16 and W=8 instances, table-driven
// expressions with a result scoreboard plus hand-written corner sequences.
module tb_expr_eval;
   logic clk = 1'b0;
   logic clr_n = 1'b0;
   always #5 clk = ~clk;

   expr_eval_if #(.W(16)) b16 ();
   expr_eval_if #(.W(8))  b8 ();

   expr_eval #(.W(16)) u16 (.clk(clk), .clr_n(clr_n), .bus(b16.slave));
   expr_eval #(.W(8))  u8  (.clk(clk), .clr_n(clr_n), .bus(b8.slave));

   typedef struct {
      bit          is_err;
      logic [15:0] res;
      bit          ovf;
   } exp_t;

   typedef struct {
      string s;
      bit    is_err;
      int    res;
   } vec_t;

   exp_t q16[$];
   exp_t q8[$];
   int   n_cmp = 0;
   int   n_bad = 0;

`ifdef EXPR_SAT_EN
   localparam int  SAT8_RES = 255;
   localparam bit  SAT8_OVF = 1'b1;
`else
   localparam int  SAT8_RES = 217;
   localparam bit  SAT8_OVF = 1'b0;
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (clr_n && (b16.res_valid || b16.err)) begin
         if (q16.size() == 0) chk("pulse16_unexpected", {b16.res_valid, b16.err}, 0);
         else begin
            e = q16.pop_front();
            chk("err16", b16.err, e.is_err);
            chk("res_valid16", b16.res_valid, !e.is_err);
            chk("result16", b16.result, e.res);
            chk("ovf16", b16.ovf, e.ovf);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (clr_n && (b8.res_valid || b8.err)) begin
         if (q8.size() == 0) chk("pulse8_unexpected", {b8.res_valid, b8.err}, 0);
         else begin
            e = q8.pop_front();
            chk("err8", b8.err, e.is_err);
            chk("res_valid8", b8.res_valid, !e.is_err);
            chk("result8", b8.result, e.res);
            chk("ovf8", b8.ovf, e.ovf);
         end
      end
   end

   task automatic put16(input logic [7:0] c);
      b16.in_valid = 1'b1;
      b16.in = c;
      @(posedge clk);
      #1;
   endtask

   task automatic put8(input logic [7:0] c);
      b8.in_valid = 1'b1;
      b8.in = c;
      @(posedge clk);
      #1;
   endtask

   task automatic send16(input string s, input bit e, input int r);
      for (int i = 0; i < s.len(); i++) begin
         if (s[i] == 8'h3D) q16.push_back('{e, 16'(r), 1'b0});
         put16(s[i]);
      end
   endtask

   task automatic send8(input string s, input bit e, input int r, input bit o);
      for (int i = 0; i < s.len(); i++) begin
         if (s[i] == 8'h3D) q8.push_back('{e, 16'(r), o});
         put8(s[i]);
      end
   endtask

   task automatic drain(input string name);
      b16.in_valid = 1'b0;
      b8.in_valid = 1'b0;
      for (int k = 0; k < 8 && (q16.size() != 0 || q8.size() != 0); k++) @(negedge clk);
      chk({name, "_q16_drained"}, q16.size(), 0);
      chk({name, "_q8_drained"}, q8.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tv[11];
      tv[0]  = '{"2*3*4+5=",     1'b0, 29};
      tv[1]  = '{"0=",           1'b0, 0};
      tv[2]  = '{"1++2=",        1'b1, 0};
      tv[3]  = '{"9=",           1'b0, 9};
      tv[4]  = '{"7*8+6*5*2=",   1'b0, 116};
      tv[5]  = '{"=",            1'b1, 116};
      tv[6]  = '{"a=",           1'b1, 116};
      tv[7]  = '{"3*=",          1'b1, 116};
      tv[8]  = '{"9*9*9*9+1=",   1'b0, 6562};
      tv[9]  = '{"12=",          1'b1, 6562};
      tv[10] = '{"0*5+4=",       1'b0, 4};

      b16.in_valid = 1'b0; b16.in = 8'h00;
      b8.in_valid  = 1'b0; b8.in  = 8'h00;
      #12;
      chk("rst_ok",        b16.ok, 0);
      chk("rst_res_valid", b16.res_valid, 0);
      chk("rst_result",    b16.result, 0);
      chk("rst_err",       b16.err, 0);
      chk("rst_ovf",       b16.ovf, 0);
      @(posedge clk); #1;
      clr_n = 1'b1;
      @(posedge clk); #1;

      // "1+2*3=" with ok after every char
      put16("1"); chk("ok_after_1", b16.ok, 1);
      put16("+"); chk("ok_after_plus", b16.ok, 0);
      put16("2"); chk("ok_after_2", b16.ok, 1);
      put16("*"); chk("ok_after_star", b16.ok, 0);
      put16("3"); chk("ok_after_3", b16.ok, 1);
      q16.push_back('{1'b0, 16'd7, 1'b0});
      put16("=");  chk("ok_after_eq", b16.ok, 0);
      drain("t1");

      // back-to-back table of expressions, no idle between them
      for (int i = 0; i < 11; i++) send16(tv[i].s, tv[i].is_err, tv[i].res);
      drain("table");
      chk("result_held", b16.result, 4);

      // reset in the middle of "5*"
      put16("5"); put16("*");
      b16.in_valid = 1'b0;
      @(negedge clk);
      clr_n = 1'b0;
      #1;
      chk("midrst_ok",        b16.ok, 0);
      chk("midrst_res_valid", b16.res_valid, 0);
      chk("midrst_result",    b16.result, 0);
      chk("midrst_err",       b16.err, 0);
      chk("midrst_ovf",       b16.ovf, 0);
      @(posedge clk); #1;
      clr_n = 1'b1;
      send16("3=", 1'b0, 3);
      drain("after_rst");

      // idle cycles with junk on 'in' inside an expression
      put16("4");
      b16.in_valid = 1'b0;
      b16.in = "+";  @(posedge clk); #1;
      b16.in = "=";  @(posedge clk); #1;
      b16.in = "7";  @(posedge clk); #1;
      chk("ok_held_idle", b16.ok, 1);
      send16("=", 1'b0, 4);
      drain("idle");
      send16("=", 1'b1, 4);
      send16("a=", 1'b1, 4);
      drain("lone_eq");

      // W=8 wrap / saturation, then ovf clears on the next expression
      send8("9*9*9=", 1'b0, SAT8_RES, SAT8_OVF);
      drain("w8_sat");
      send8("1=", 1'b0, 1, 1'b0);
      drain("w8_next");
      chk("w8_ovf_clear", b8.ovf, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
